// File: rtl/fpu_check_pkg.sv
// Shared encodings for the FPU result checker: compare classes and checker states.
package fpu_check_pkg;

  localparam logic [1:0] CLS_MATCH    = 2'd0;
  localparam logic [1:0] CLS_ROUND    = 2'd1;
  localparam logic [1:0] CLS_MISMATCH = 2'd2;
  localparam logic [1:0] CLS_ORPHAN   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FAIL   = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_check_fifo.sv
// Synchronous FIFO holding expected result words; full/empty come from a registered
// occupancy count that carries one extra bit so the two states never alias.
module fpu_check_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fpu_result_checker.sv
// Self-checking monitor on the FPU result stream. Define FPU_CHECK_ROUND_TOL_EN to
// accept +/-1 LSB differences as a tolerated rounding class instead of a mismatch.
module fpu_result_checker
  import fpu_check_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ExpValid,
  input  logic [31:0]            ExpData,
  output logic                   ExpReady,
  input  logic                   ResValid,
  input  logic [31:0]            Result,
  output logic                   CmpValid,
  output logic [1:0]             CmpClass,
  output logic [CNT_W-1:0]       MatchCount,
  output logic [CNT_W-1:0]       RoundCount,
  output logic [CNT_W-1:0]       MismatchCount,
  output logic [CNT_W-1:0]       OrphanCount,
  output logic [$clog2(DEPTH):0] Pending,
  output logic                   Pass,
  output logic                   Fail
);

  logic [31:0] head;
  logic [31:0] diff;
  logic        full;
  logic        empty;
  logic        near;
  logic [1:0]  cls;
  logic        bad;
  state_t      state;
  state_t      state_nxt;

  fpu_check_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (ExpValid),
    .pop   (ResValid),
    .din   (ExpData),
    .head  (head),
    .count (Pending),
    .full  (full),
    .empty (empty)
  );

  assign ExpReady = ~full;
  assign diff     = Result - head;
  assign near     = (diff == 32'h0000_0001) || (diff == 32'hFFFF_FFFF);

  // An empty FIFO never bypasses a same-cycle push: the result is an orphan.
  always_comb begin
    cls = CLS_MISMATCH;
    if (empty)               cls = CLS_ORPHAN;
    else if (Result == head) cls = CLS_MATCH;
    else if (near)
`ifdef FPU_CHECK_ROUND_TOL_EN
      cls = CLS_ROUND;
`else
      cls = CLS_MISMATCH;
`endif
  end

  assign bad = (cls == CLS_MISMATCH) || (cls == CLS_ORPHAN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      CmpValid      <= 1'b0;
      CmpClass      <= CLS_MATCH;
      MatchCount    <= '0;
      MismatchCount <= '0;
      OrphanCount   <= '0;
    end else begin
      CmpValid <= ResValid;
      if (ResValid) begin
        CmpClass <= cls;
        if (cls == CLS_MATCH && ~&MatchCount)       MatchCount    <= MatchCount + 1'b1;
        if (cls == CLS_MISMATCH && ~&MismatchCount) MismatchCount <= MismatchCount + 1'b1;
        if (cls == CLS_ORPHAN && ~&OrphanCount)     OrphanCount   <= OrphanCount + 1'b1;
      end
    end
  end

`ifdef FPU_CHECK_ROUND_TOL_EN
  always_ff @(posedge CLK) begin
    if (RST)                                                RoundCount <= '0;
    else if (ResValid && cls == CLS_ROUND && ~&RoundCount)  RoundCount <= RoundCount + 1'b1;
  end
`else
  assign RoundCount = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The state moves on the same edge that raises CmpValid for the deciding compare.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ResValid) state_nxt = bad ? ST_FAIL : ST_ACTIVE;
      ST_ACTIVE: if (ResValid && bad) state_nxt = ST_FAIL;
      ST_FAIL:   state_nxt = ST_FAIL;
      default:   state_nxt = ST_FAIL;
    endcase
  end

  always_comb begin
    Pass = (state == ST_IDLE) || (state == ST_ACTIVE);
    Fail = (state == ST_FAIL);
  end

endmodule

// File: doc/fpu_result_checker.md
# fpu_result_checker

Synthesizable self-checking monitor that sits on the FPU `Result` output and consumes the same stream of expected words that the stimulus side produces. Expected values are queued in an internal FIFO as operations are issued. Each FPU result pops one entry and is classified as match, rounding error (±1 LSB), mismatch, or orphan (no expected value pending). Per-class counters and a sticky pass/fail status let silicon and FPGA builds self-check without a simulator file dump.

## Interface
Parameters:
- `DEPTH`, 16: expected-value FIFO depth; power of two, at least 2.
- `CNT_W`, 16: width of each class counter.

Ports:
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST` in 1: synchronous, active-high reset.
- `ExpValid` in 1: push `ExpData` this cycle.
- `ExpData` in 32: expected IEEE-754 single result.
- `ExpReady` out 1: FIFO not full; a push is accepted only when `ExpValid & ExpReady`.
- `ResValid` in 1: `Result` is valid this cycle.
- `Result` in 32: FPU result word.
- `CmpValid` out 1: one-cycle pulse; the classification is valid.
- `CmpClass` out 2: 0 = match, 1 = rounding, 2 = mismatch, 3 = orphan.
- `MatchCount`, `RoundCount`, `MismatchCount`, `OrphanCount` out CNT_W each: saturating counters.
- `Pending` out $clog2(DEPTH)+1: FIFO occupancy.
- `Pass` out 1: high while in IDLE or ACTIVE.
- `Fail` out 1: high in FAIL.

## Operation
- State machine:
  - IDLE: no compare has occurred since reset. Goes to ACTIVE on the first compare classed match or rounding. Goes to FAIL on the first compare classed mismatch or orphan.
  - ACTIVE: goes to FAIL on any mismatch or orphan.
  - FAIL: sticky; left only by `RST`.
- Compare, on a `ResValid` cycle:
  - If FIFO is non-empty, pop the head and compare it with `Result`.
  - If FIFO is empty, the class is orphan and nothing is popped.
- Class rules:
  - match: `Result == head`, exact 32-bit equality.
  - rounding: `(Result - head) mod 2^32` equals 32'h0000_0001 or 32'hFFFF_FFFF.
  - mismatch: every other case.
- Counters: the counter for the decided class increments by 1 and saturates at all-ones.
- FIFO full: `ExpReady` = 0 and the push is dropped. A pop in the same cycle does not rescue that push, because `ExpReady` is computed from registered occupancy.
- Empty FIFO with push and `ResValid` in the same cycle: the result is classed orphan. There is no bypass of the pushed word, and the push is still accepted.
- Simultaneous push and pop on a non-empty, non-full FIFO: `Pending` is unchanged.
- Pointers wrap modulo `DEPTH`. Occupancy is tracked in the extra bit, so full and empty are distinct.

## Timing
- Compare latency is 1 cycle: `ResValid` sampled at edge N gives `CmpValid`/`CmpClass` at edge N+1, and counters update at that same edge.
- `Pending` and `ExpReady` reflect state after edge N.
- `Pass`/`Fail` change in the same cycle as the `CmpValid` that caused the transition.
- Reset values:
  - FIFO empty; `Pending` = 0; `ExpReady` = 1.
  - `CmpValid` = 0; `CmpClass` = 0.
  - All counters = 0.
  - State IDLE: `Pass` = 1, `Fail` = 0.
- Reset asserted mid-stream: all queued expected words are discarded and no `CmpValid` is issued for a `ResValid` in the reset cycle.
- Back-to-back `ResValid` is allowed: one classification per cycle, full throughput.

## Configuration
- `FPU_CHECK_ROUND_TOL_EN` defined: the rounding class exists as described and does not cause FAIL.
- Not defined:
  - A ±1 LSB difference is classed mismatch and drives FAIL.
  - `RoundCount` is tied to 0.
  - `CmpClass` never equals 1.

## Structure
- Package `fpu_check_pkg` holds:
  - The class encoding constants `CLS_MATCH`, `CLS_ROUND`, `CLS_MISMATCH`, `CLS_ORPHAN`.
  - The state encoding for IDLE, ACTIVE and FAIL.
- Sub-module `fpu_check_fifo` is a synchronous FIFO, parameterized by `DEPTH` and data width, with push, pop, head, count, full and empty. It reuses the same `CLK`/`RST`.
- Classifier, counters and FSM live in `fpu_result_checker`.

## Test plan
- Push 32'h3F800000, then `ResValid` with `Result`=32'h3F800000:
  - `CmpClass`=0 one cycle later; `MatchCount`=1; state ACTIVE; `Pass`=1.
- Push 32'h40490FDB, then `Result`=32'h40490FDC:
  - With `FPU_CHECK_ROUND_TOL_EN`: `CmpClass`=1, `RoundCount`=1, `Pass`=1.
  - Without it: `CmpClass`=2, `Fail`=1.
- `ResValid` with FIFO empty:
  - `CmpClass`=3; `OrphanCount`=1; `Fail`=1.
  - `Fail` stays 1 after a later match.
- Fill to `DEPTH`=16:
  - `ExpReady`=0 and a 17th push is dropped; `Pending`=16.
  - Then 16 matching results: 16 matches; `Pending`=0; pointers wrap correctly on a refill.
- Push 3 words, then assert `RST` for one cycle:
  - `Pending`=0 and counters are 0.
  - The next `ResValid` is classed orphan.
